// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: byte FIFO plus pacing sequencer in front of spi_tx.
// Queued bytes are handed over with a one-cycle spi_rd_en load pulse. Each
// byte is then paced with ten evenly spaced spi_wr_en strobes (START, eight
// data bits MSB first, END), followed by a one-cycle gap.
// Optional feature macro: SPI_FEEDER_SCLK_EN adds the sclk output.
module spi_tx_feeder #(
  parameter int DEPTH = 4,
  parameter int DIV   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     spi_rd_en,
  output logic [7:0]               spi_data,
  output logic                     spi_wr_en,
  output logic                     busy,
`ifdef SPI_FEEDER_SCLK_EN
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     sclk
`else
  output logic [$clog2(DEPTH):0]   fifo_count
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(DIV);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [3:0]     LAST_TICK = 4'd9;

  typedef enum logic [1:0] {
    FB_IDLE = 2'd0,
    FB_LOAD = 2'd1,
    FB_RUN  = 2'd2,
    FB_GAP  = 2'd3
  } fb_state_t;

  fb_state_t        state_r;
  logic [7:0]       mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [DCW-1:0]   div_cnt_r;
  logic [3:0]       tick_cnt_r;
  logic             push_s;
  logic             pop_s;

  // The FSM only enters FB_LOAD with count_r > 0, so a pop never underflows.
  assign in_ready   = (count_r < DEPTH_C);
  assign push_s     = in_valid && in_ready;
  assign pop_s      = (state_r == FB_LOAD);
  assign fifo_count = count_r;
  assign busy       = (state_r != FB_IDLE) || (count_r != {CW{1'b0}});
  assign spi_rd_en  = (state_r == FB_LOAD);
  assign spi_wr_en  = (state_r == FB_RUN) && (div_cnt_r == DIV_LAST);
  assign spi_data   = spi_rd_en ? mem_r[rd_ptr_r] : 8'h00;

`ifdef SPI_FEEDER_SCLK_EN
  // sclk is high in the second half of the periods that follow strobes
  // 2..9, so the receiver samples mid-bit once data_out has settled.
  assign sclk = (state_r == FB_RUN) && (tick_cnt_r >= 4'd2) &&
                (tick_cnt_r <= LAST_TICK) && (div_cnt_r >= DCW'(DIV / 2));
`endif

  // FIFO storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencer: load pulse, ten paced strobes, one-cycle gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FB_IDLE;
      div_cnt_r  <= {DCW{1'b0}};
      tick_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        FB_IDLE: begin
          if (count_r != {CW{1'b0}}) begin
            state_r <= FB_LOAD;
          end
        end
        FB_LOAD: begin
          div_cnt_r  <= {DCW{1'b0}};
          tick_cnt_r <= 4'd0;
          state_r    <= FB_RUN;
        end
        FB_RUN: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r  <= {DCW{1'b0}};
            tick_cnt_r <= tick_cnt_r + 4'd1;
            if (tick_cnt_r == LAST_TICK) begin
              state_r <= FB_GAP;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DCW'(1);
          end
        end
        FB_GAP: begin
          state_r <= FB_IDLE;
        end
        default: begin
          state_r <= FB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed bench for spi_tx_feeder (DEPTH=4, DIV=8). A negedge monitor logs
// load pulses, strobes and the bits a spi_tx would shift out; the initial
// block drives directed steps and checks against hand-computed values.
module tb_spi_tx_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       spi_rd_en;
  logic [7:0] spi_data;
  logic       spi_wr_en;
  logic       busy;
  logic [2:0] fifo_count;
`ifdef SPI_FEEDER_SCLK_EN
  logic       sclk;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         rd_cyc_q[$];
  logic [7:0] rd_dat_q[$];
  int         wr_cyc_q[$];
  logic       bit_q[$];

  logic [7:0] sr_m;
  int         k_m;
  logic       dout_m;
`ifdef SPI_FEEDER_SCLK_EN
  logic       sclk_prev;
  int         sclk_rises;
  logic       dout_first;
`endif

  spi_tx_feeder #(.DEPTH(4), .DIV(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .spi_rd_en  (spi_rd_en),
    .spi_data   (spi_data),
    .spi_wr_en  (spi_wr_en),
    .busy       (busy),
`ifdef SPI_FEEDER_SCLK_EN
    .fifo_count (fifo_count),
    .sclk       (sclk)
`else
    .fifo_count (fifo_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log and a behavioural spi_tx shift model
  always @(negedge clk) begin
    if (!rst_n) begin
      k_m    = 0;
      sr_m   = 8'h00;
      dout_m = 1'b0;
    end else begin
      if (spi_rd_en) begin
        rd_cyc_q.push_back(cyc);
        rd_dat_q.push_back(spi_data);
        sr_m = spi_data;
        k_m  = 0;
      end
      if (spi_wr_en) begin
        wr_cyc_q.push_back(cyc);
        k_m = k_m + 1;
        if (k_m >= 2 && k_m <= 9) begin
          dout_m = sr_m[7];
          bit_q.push_back(sr_m[7]);
          sr_m = {sr_m[6:0], 1'b0};
        end
      end
    end
`ifdef SPI_FEEDER_SCLK_EN
    if (sclk && !sclk_prev) begin
      if (sclk_rises == 0) dout_first = dout_m;
      sclk_rises = sclk_rises + 1;
    end
    sclk_prev = sclk;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the FIFO accepts it (bounded)
  task automatic push(input logic [7:0] b);
    logic acc;
    in_data  = b;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("push_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_strobes(input int target);
    for (int i = 0; i < 2000 && wr_cyc_q.size() < target; i++) step();
    chk("strobe_wait", (wr_cyc_q.size() >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int         rb, wb, bb;
  logic [7:0] exp_byte;
  logic [7:0] exp_seq [6];
  int         exp_cnt [6];

  initial begin
`ifdef SPI_FEEDER_SCLK_EN
    sclk_prev  = 1'b0;
    sclk_rises = 0;
    dout_first = 1'b0;
`endif
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) step();

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_rd_en", {31'd0, spi_rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, spi_wr_en}, 32'd0);
    chk("rst_data", {24'd0, spi_data}, 32'd0);
`ifdef SPI_FEEDER_SCLK_EN
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Single byte 0xA5
    rb = rd_cyc_q.size(); wb = wr_cyc_q.size(); bb = bit_q.size();
    push(8'hA5);
    chk("a5_count", {29'd0, fifo_count}, 32'd1);
    wait_strobes(wb + 10);
    chk("a5_rd_num", rd_cyc_q.size() - rb, 32'd1);
    chk("a5_data", {24'd0, rd_dat_q[rb]}, 32'hA5);
    for (int k = 0; k < 10; k++)
      chk($sformatf("a5_strobe%0d", k + 1), wr_cyc_q[wb + k] - rd_cyc_q[rb], 8 * (k + 1));
    exp_byte = 8'b1010_0101;
    for (int i = 0; i < 8; i++)
      chk($sformatf("a5_bit%0d", i), {31'd0, bit_q[bb + i]}, {31'd0, exp_byte[7 - i]});
    step();
    chk("a5_gap_busy", {31'd0, busy}, 32'd1);
    step();
    chk("a5_idle_busy", {31'd0, busy}, 32'd0);
    repeat (5) step();

    // Six bytes back-to-back: fills the FIFO, sixth waits while full
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    exp_seq[3] = 8'h44; exp_seq[4] = 8'h55; exp_seq[5] = 8'h66;
    exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 2;
    exp_cnt[3] = 3; exp_cnt[4] = 4; exp_cnt[5] = 4;
    rb = rd_cyc_q.size(); wb = wr_cyc_q.size();
    for (int i = 0; i < 6; i++) begin
      push(exp_seq[i]);
      chk($sformatf("b2b_count%0d", i), {29'd0, fifo_count}, exp_cnt[i]);
      if (i == 4) chk("b2b_full_ready", {31'd0, in_ready}, 32'd0);
    end
    wait_strobes(wb + 60);
    chk("b2b_rd_num", rd_cyc_q.size() - rb, 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("b2b_data%0d", i), {24'd0, rd_dat_q[rb + i]}, {24'd0, exp_seq[i]});
    for (int i = 1; i < 6; i++)
      chk($sformatf("b2b_period%0d", i), rd_cyc_q[rb + i] - rd_cyc_q[rb + i - 1], 32'd83);
    repeat (5) step();
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a transfer, one byte still queued
    rb = rd_cyc_q.size(); wb = wr_cyc_q.size();
    push(8'h3C);
    push(8'hC3);
    wait_strobes(wb + 5);
    chk("mid_count_before", {29'd0, fifo_count}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wr_en", {31'd0, spi_wr_en}, 32'd0);
    chk("mid_count", {29'd0, fifo_count}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("mid_wr_en_next", {31'd0, spi_wr_en}, 32'd0);
    rst_n = 1'b1;
    repeat (20) step();
    chk("mid_no_reload", rd_cyc_q.size() - rb, 32'd1);
    chk("mid_still_idle", {31'd0, busy}, 32'd0);

`ifdef SPI_FEEDER_SCLK_EN
    // 0x80: eight sclk rising edges, first data bit is 1
    sclk_rises = 0;
    wb = wr_cyc_q.size();
    push(8'h80);
    wait_strobes(wb + 10);
    repeat (4) step();
    chk("sclk_rises", sclk_rises, 32'd8);
    chk("sclk_first_bit", {31'd0, dout_first}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
